// File: rtl/scc_mem_pkg.sv
// Shared definitions for the single-cycle core memory responder:
// register-window layout, address-decode classes and decode helpers.
package scc_mem_pkg;

  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
  localparam logic [31:0] CNT_OFS   = 32'h0000_0000;
  localparam logic [31:0] LATCH_OFS = 32'h0000_0004;

  // Where a data-port address lands.
  typedef enum logic [1:0] {
    RAM,
    CNT,
    LATCH,
    BAD
  } addr_sel_e;

  // True when a byte address is word aligned and inside a RAM of ram_bytes.
  function automatic logic word_ok(input logic [31:0] addr,
                                   input logic [31:0] ram_bytes);
    return (addr[1:0] == 2'b00) && (addr < ram_bytes);
  endfunction

  // Classify a data-port address: RAM first, then the two window registers.
  function automatic addr_sel_e decode_data(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] ram_bytes);
    addr_sel_e sel;
    if (addr[1:0] != 2'b00) begin
      sel = BAD;
    end else if (addr < ram_bytes) begin
      sel = RAM;
    end else if (addr == base + CNT_OFS) begin
      sel = CNT;
    end else if (addr == base + LATCH_OFS) begin
      sel = LATCH;
    end else begin
      sel = BAD;
    end
    return sel;
  endfunction

endpackage

// File: rtl/scc_mem_responder_ram.sv
// Word-wide synchronous RAM: one write port, one registered read port.
// The read register only loads on re_i, so rdata_o holds between reads.
module scc_sync_ram #(
  parameter int unsigned WORDS = 256,
  localparam int unsigned AW   = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rdata_q;

  // Storage array: written at the edge, contents survive reset.
  // NOTE: the array has no reset branch so it maps onto RAM macros; only the read register is reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      // NOTE: non-blocking assignment keeps every register updating from pre-edge values.
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port with synchronous reset to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/scc_mem_responder.sv
// Memory-side responder for the single-cycle core: instruction RAM with a
// preload port, data RAM, and a register window holding a free-running
// cycle counter and an output latch. Bad accesses set a sticky fault.
module scc_mem_responder #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256,
  parameter logic [31:0] MMIO_BASE  = scc_mem_pkg::MMIO_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_mem_en,
  input  logic [31:0] in_mem_addr,
  output logic [31:0] in_mem,
  output logic        instr_valid,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  input  logic        data_read,
  input  logic        data_write,
  output logic [31:0] data_in,
  output logic        data_valid,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic [31:0] out_latch,
  output logic        fault
);

  import scc_mem_pkg::addr_sel_e, scc_mem_pkg::RAM, scc_mem_pkg::CNT,
         scc_mem_pkg::LATCH, scc_mem_pkg::BAD;
  import scc_mem_pkg::word_ok, scc_mem_pkg::decode_data;

  localparam int unsigned IAW        = $clog2(IMEM_WORDS);
  localparam int unsigned DAW        = $clog2(DMEM_WORDS);
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);

  // Request qualification. Preload wins over fetch; a simultaneous read and
  // write on the data port performs neither.
  logic      load_ok;
  logic      fetch_req;
  logic      fetch_ok;
  logic      rd_req;
  logic      wr_req;
  logic      both_req;
  addr_sel_e data_sel;

  assign load_ok   = load_en && word_ok(load_addr, IMEM_BYTES);
  assign fetch_req = in_mem_en && !load_en;
  assign fetch_ok  = fetch_req && word_ok(in_mem_addr, IMEM_BYTES);
  assign rd_req    = data_read && !data_write;
  assign wr_req    = data_write && !data_read;
  assign both_req  = data_read && data_write;
  assign data_sel  = decode_data(data_addr, MMIO_BASE, DMEM_BYTES);

  // Registered state.
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] latch_q, latch_d;
  logic        fault_q, fault_d;
  logic        instr_valid_q, instr_valid_d;
  logic        fetch_bad_q, fetch_bad_d;
  logic        data_valid_q, data_valid_d;
  addr_sel_e   rd_sel_q, rd_sel_d;
  logic [31:0] mmio_rdata_q, mmio_rdata_d;

  logic [31:0] imem_rdata;
  logic [31:0] dmem_rdata;

  // Next-state for counter, latch, response tags and the sticky fault.
  always_comb begin
    // NOTE: every _d gets a default first so no path through this block infers a latch.
    cnt_d         = cnt_q + 32'd1;
    latch_d       = latch_q;
    instr_valid_d = fetch_req;
    fetch_bad_d   = fetch_bad_q;
    data_valid_d  = rd_req;
    rd_sel_d      = rd_sel_q;
    mmio_rdata_d  = mmio_rdata_q;
    fault_d       = fault_q;

    if (fetch_req) begin
      fetch_bad_d = !fetch_ok;
    end

    if (wr_req && (data_sel == LATCH)) begin
      latch_d = data_out;
    end

    // Window reads return the counter as it stands after this edge.
    if (rd_req) begin
      rd_sel_d = data_sel;
      case (data_sel)
        CNT:     mmio_rdata_d = cnt_d;
        LATCH:   mmio_rdata_d = latch_q;
        default: mmio_rdata_d = '0;
      endcase
    end

    if (both_req ||
        (fetch_req && !fetch_ok) ||
        (rd_req && (data_sel == BAD)) ||
        (wr_req && ((data_sel == BAD) || (data_sel == CNT)))) begin
      fault_d = 1'b1;
    end
  end

  // State registers; reset drops any request sampled in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      latch_q       <= '0;
      fault_q       <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_bad_q   <= 1'b0;
      data_valid_q  <= 1'b0;
      rd_sel_q      <= BAD;
      mmio_rdata_q  <= '0;
    end else begin
      cnt_q         <= cnt_d;
      latch_q       <= latch_d;
      fault_q       <= fault_d;
      instr_valid_q <= instr_valid_d;
      fetch_bad_q   <= fetch_bad_d;
      data_valid_q  <= data_valid_d;
      rd_sel_q      <= rd_sel_d;
      mmio_rdata_q  <= mmio_rdata_d;
    end
  end

  scc_sync_ram #(
    .WORDS (IMEM_WORDS)
  ) u_imem (
    .clk     (clk),
    .reset   (reset),
    .we_i    (load_ok && !reset),
    .waddr_i (load_addr[IAW+1:2]),
    .wdata_i (load_data),
    .re_i    (fetch_ok),
    .raddr_i (in_mem_addr[IAW+1:2]),
    .rdata_o (imem_rdata)
  );

  scc_sync_ram #(
    .WORDS (DMEM_WORDS)
  ) u_dmem (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wr_req && (data_sel == RAM) && !reset),
    .waddr_i (data_addr[DAW+1:2]),
    .wdata_i (data_out),
    .re_i    (rd_req && (data_sel == RAM)),
    .raddr_i (data_addr[DAW+1:2]),
    .rdata_o (dmem_rdata)
  );

  assign in_mem      = fetch_bad_q ? 32'd0 : imem_rdata;
  assign instr_valid = instr_valid_q;
  assign data_in     = (rd_sel_q == RAM) ? dmem_rdata : mmio_rdata_q;
  assign data_valid  = data_valid_q;
  assign out_latch   = latch_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_scc_mem_responder.sv
// Self-checking bench for scc_mem_responder: a cycle-level behavioural model
// predicts every output, a negedge process compares, and directed steps
// add hand-computed literal checks.
module tb_scc_mem_responder;

  localparam int unsigned IMEM_WORDS = 256;
  localparam int unsigned DMEM_WORDS = 256;
  localparam logic [31:0] BASE       = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_mem_en;
  logic [31:0] in_mem_addr;
  logic [31:0] in_mem;
  logic        instr_valid;
  logic [31:0] data_addr;
  logic [31:0] data_out;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_in;
  logic        data_valid;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic [31:0] out_latch;
  logic        fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scc_mem_responder #(
    .IMEM_WORDS (IMEM_WORDS),
    .DMEM_WORDS (DMEM_WORDS),
    .MMIO_BASE  (BASE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_mem_en   (in_mem_en),
    .in_mem_addr (in_mem_addr),
    .in_mem      (in_mem),
    .instr_valid (instr_valid),
    .data_addr   (data_addr),
    .data_out    (data_out),
    .data_read   (data_read),
    .data_write  (data_write),
    .data_in     (data_in),
    .data_valid  (data_valid),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .out_latch   (out_latch),
    .fault       (fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_imem [IMEM_WORDS];
  logic [31:0] m_dmem [DMEM_WORDS];
  logic [31:0] m_cycles = 0;   // cycles since reset release
  logic [31:0] m_latch  = 0;
  logic        m_fault  = 0;
  logic [31:0] e_in_mem = 0;
  logic        e_iv     = 0;
  logic [31:0] e_din    = 0;
  logic        e_dv     = 0;
  logic        e_din_chk = 0;
  logic        started  = 0;

  always @(posedge clk) begin
    started = 1'b1;
    if (reset) begin
      m_cycles = 0; m_latch = 0; m_fault = 0;
      e_in_mem = 0; e_iv = 0; e_din = 0; e_dv = 0; e_din_chk = 1'b1;
    end else begin
      // instruction side
      e_iv = 1'b0;
      if (load_en) begin
        if (load_addr % 4 == 0 && load_addr < IMEM_WORDS * 4)
          m_imem[int'(load_addr / 4)] = load_data;
      end else if (in_mem_en) begin
        e_iv = 1'b1;
        if (in_mem_addr % 4 == 0 && in_mem_addr < IMEM_WORDS * 4)
          e_in_mem = m_imem[int'(in_mem_addr / 4)];
        else begin
          e_in_mem = 0; m_fault = 1'b1;
        end
      end
      // data side
      e_dv = 1'b0;
      if (data_read && data_write) begin
        m_fault = 1'b1;
      end else if (data_read) begin
        e_dv = 1'b1;
        if (data_addr % 4 != 0) begin
          e_din = 0; m_fault = 1'b1;
        end else if (data_addr < DMEM_WORDS * 4) e_din = m_dmem[int'(data_addr / 4)];
        else if (data_addr == BASE)              e_din = m_cycles + 1;
        else if (data_addr == BASE + 4)          e_din = m_latch;
        else begin
          e_din = 0; m_fault = 1'b1;
        end
      end else if (data_write) begin
        if (data_addr % 4 != 0)                  m_fault = 1'b1;
        else if (data_addr < DMEM_WORDS * 4)     m_dmem[int'(data_addr / 4)] = data_out;
        else if (data_addr == BASE + 4)          m_latch = data_out;
        else                                     m_fault = 1'b1;
      end
      e_din_chk = e_dv;
      m_cycles  = m_cycles + 1;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      check("m_in_mem", in_mem, e_in_mem);
      check("m_instr_valid", {31'd0, instr_valid}, {31'd0, e_iv});
      check("m_data_valid", {31'd0, data_valid}, {31'd0, e_dv});
      if (e_din_chk) check("m_data_in", data_in, e_din);
      check("m_out_latch", out_latch, m_latch);
      check("m_fault", {31'd0, fault}, {31'd0, m_fault});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_mem_en = 0; load_en = 0; data_read = 0; data_write = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    idle(); data_write = 1; data_addr = a; data_out = d; step();
  endtask

  task automatic rd(input logic [31:0] a);
    idle(); data_read = 1; data_addr = a; step();
  endtask

  task automatic fetch(input logic [31:0] a);
    idle(); in_mem_en = 1; in_mem_addr = a; step();
  endtask

  task automatic pulse_reset();
    idle(); reset = 1; step(); reset = 0;
  endtask

  initial begin
    reset = 1; idle();
    in_mem_addr = 0; data_addr = 0; data_out = 0; load_addr = 0; load_data = 0;
    repeat (3) step();
    check("rst_in_mem", in_mem, 32'h0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'h0);
    check("rst_data_in", data_in, 32'h0);
    check("rst_data_valid", {31'd0, data_valid}, 32'h0);
    check("rst_out_latch", out_latch, 32'h0);
    check("rst_fault", {31'd0, fault}, 32'h0);
    reset = 0;

    // Preload words 0..3; last preload collides with a fetch, which is dropped.
    for (int i = 0; i < 4; i++) begin
      idle(); load_en = 1; load_addr = 32'(4 * i); load_data = 32'(17 * (i + 1));
      if (i == 3) begin
        in_mem_en = 1; in_mem_addr = 0;
      end
      step();
    end
    check("drop_fetch_iv", {31'd0, instr_valid}, 32'h0);
    idle(); load_en = 1; load_addr = 32'h3FC; load_data = 32'hCAFE_F00D; step();

    // Back-to-back fetches.
    for (int i = 0; i < 4; i++) begin
      fetch(32'(4 * i));
      check("fetch_word", in_mem, 32'(17 * (i + 1)));
      check("fetch_iv", {31'd0, instr_valid}, 32'h1);
    end
    fetch(32'h3FC);
    check("fetch_last", in_mem, 32'hCAFE_F00D);
    idle(); step();
    check("fetch_idle_iv", {31'd0, instr_valid}, 32'h0);
    check("fetch_hold", in_mem, 32'hCAFE_F00D);

    // Data RAM write then read-back.
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10);
    check("rd_after_wr", data_in, 32'hDEAD_BEEF);
    check("rd_after_wr_dv", {31'd0, data_valid}, 32'h1);
    check("rd_after_wr_fault", {31'd0, fault}, 32'h0);
    wr(32'h3FC, 32'h5555_AAAA);
    rd(32'h3FC);
    check("rd_last_word", data_in, 32'h5555_AAAA);

    // Register window.
    wr(BASE + 4, 32'hA5);
    check("latch_wr", out_latch, 32'hA5);
    rd(BASE + 4);
    check("latch_rd", data_in, 32'hA5);
    wr(BASE, 32'h1234);
    check("cnt_wr_fault", {31'd0, fault}, 32'h1);
    rd(BASE);

    pulse_reset();
    check("rst2_fault", {31'd0, fault}, 32'h0);
    check("rst2_latch", out_latch, 32'h0);

    // Misaligned read, fault sticky.
    rd(32'h13);
    check("misal_data", data_in, 32'h0);
    check("misal_dv", {31'd0, data_valid}, 32'h1);
    check("misal_fault", {31'd0, fault}, 32'h1);
    idle(); repeat (3) step();
    check("fault_sticky", {31'd0, fault}, 32'h1);

    // Read and write together: nothing happens.
    pulse_reset();
    idle(); data_read = 1; data_write = 1; data_addr = 32'h10; data_out = 32'h1234; step();
    check("both_dv", {31'd0, data_valid}, 32'h0);
    check("both_fault", {31'd0, fault}, 32'h1);
    rd(32'h10);
    check("both_ram_kept", data_in, 32'hDEAD_BEEF);

    // Unmapped data read and bad fetches.
    pulse_reset();
    rd(32'h400);
    check("unmapped_data", data_in, 32'h0);
    check("unmapped_fault", {31'd0, fault}, 32'h1);
    pulse_reset();
    fetch(32'h400);
    check("fetch_oob", in_mem, 32'h0);
    check("fetch_oob_iv", {31'd0, instr_valid}, 32'h1);
    check("fetch_oob_fault", {31'd0, fault}, 32'h1);
    fetch(32'h2);
    check("fetch_misal", in_mem, 32'h0);

    // A write sampled with reset is dropped.
    wr(32'h20, 32'h1);
    idle(); reset = 1; data_write = 1; data_addr = 32'h20; data_out = 32'h2; step();
    reset = 0;
    rd(32'h20);
    check("rst_drops_wr", data_in, 32'h1);

    // Counter read on the first cycle after a 5-cycle reset.
    idle(); reset = 1; repeat (5) step();
    reset = 0; data_read = 1; data_addr = BASE; step();
    check("cnt_first", data_in, 32'h1);
    check("cnt_first_dv", {31'd0, data_valid}, 32'h1);
    idle(); step(); step();
    rd(BASE);
    check("cnt_later", data_in, 32'h4);

    // Reset together with pending requests squashes the responses.
    idle(); reset = 1; data_read = 1; data_addr = 32'h10; in_mem_en = 1; in_mem_addr = 0; step();
    check("rst_mid_dv", {31'd0, data_valid}, 32'h0);
    check("rst_mid_iv", {31'd0, instr_valid}, 32'h0);
    reset = 0; idle(); repeat (2) step();

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
